// File: rtl/eclock_pattern_gen_pkg.sv
// ---------------------------------------------------------------------------
// eclock_pattern_gen_pkg
//
// Shared definitions for the eLink clock-pattern generator.
//   - default word width (PW) and count-field width (DW)
//   - legal serializer ratios, as a bit mask plus a lookup function
//   - cnt_t : internal phase-counter type, wide enough for any supported DW
//   - step_t: per-bit working state {en, level, cnt} passed along the step chain
// No ports; imported by the interface-facing modules.
// ---------------------------------------------------------------------------
package eclock_pattern_gen_pkg;

    localparam int ECLK_PW_DEFAULT = 8;
    localparam int ECLK_DW_DEFAULT = 8;

    // Counters are held internally at this width so the step logic does not
    // depend on DW; narrower configuration fields are zero-extended on load.
    localparam int ECLK_CNT_W = 16;

    // Bit n set means a serializer ratio of n is supported (2, 4, 6, 8, 10, 14).
    localparam logic [15:0] ECLK_PW_LEGAL_MASK = 16'h4554;

    typedef logic [ECLK_CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic en;
        logic level;
        cnt_t cnt;
    } step_t;

    function automatic bit eclk_pw_legal(input int pw);
        if (pw < 0 || pw > 15) begin
            return 1'b0;
        end
        return ECLK_PW_LEGAL_MASK[pw[3:0]];
    endfunction

endpackage

// File: rtl/eclock_pattern_gen_if.sv
// ---------------------------------------------------------------------------
// eclock_pattern_gen_if
//
// Configuration and pattern bus between the config-register block (master)
// and the pattern generator (slave).
//   cfg_load  : one-cycle strobe capturing cfg_en/cfg_high/cfg_low together
//   cfg_en    : requested enable
//   cfg_high  : serial bits spent high per period (DW bits)
//   cfg_low   : serial bits spent low per period (DW bits)
//   pattern   : PW-bit serializer word, bit 0 leaves the pin first
//   active    : the word on pattern was generated while enabled
//   pending   : a loaded configuration has not yet taken effect
// ---------------------------------------------------------------------------
interface eclock_pattern_gen_if #(
    parameter int PW = 8,
    parameter int DW = 8
);

    logic          cfg_load;
    logic          cfg_en;
    logic [DW-1:0] cfg_high;
    logic [DW-1:0] cfg_low;
    logic [PW-1:0] pattern;
    logic          active;
    logic          pending;

    modport master (
        output cfg_load, cfg_en, cfg_high, cfg_low,
        input  pattern, active, pending
    );

    modport slave (
        input  cfg_load, cfg_en, cfg_high, cfg_low,
        output pattern, active, pending
    );

endinterface

// File: rtl/eclock_pattern_step.sv
// ---------------------------------------------------------------------------
// eclock_pattern_step
//
// One serial bit-time of the clock pattern, purely combinational. The top
// level chains PW of these so that each word advances PW bit-times.
//   i_state / o_state   : {en, level, cnt} before and after this bit
//   i_high/i_low        : working high/low counts before this bit
//   o_high/o_low        : working counts after a possible shadow apply
//   i_pending/o_pending : shadow waiting to be applied, before/after this bit
//   i_sh_en             : shadow enable, already forced low for zero counts
//   i_sh_high/i_sh_low  : shadow counts
//   o_bit               : serial output bit for this position
// ---------------------------------------------------------------------------
module eclock_pattern_step
    import eclock_pattern_gen_pkg::*;
(
    input  step_t i_state,
    input  cnt_t  i_high,
    input  cnt_t  i_low,
    input  logic  i_pending,
    input  logic  i_sh_en,
    input  cnt_t  i_sh_high,
    input  cnt_t  i_sh_low,
    output step_t o_state,
    output cnt_t  o_high,
    output cnt_t  o_low,
    output logic  o_pending,
    output logic  o_bit
);

    logic  w_boundary;
    step_t w_cur;

    // A period boundary is either idle, or the last bit of a low phase. Only
    // there may a new configuration be swapped in, so a running period always
    // finishes with the counts it started with. Starting from idle forces the
    // bit to begin a fresh high phase. After choosing the bit value the state
    // advances: count down, or flip level and reload with the opposite phase.
    always_comb begin
        w_boundary = !i_state.en || (!i_state.level && (i_state.cnt == cnt_t'(1)));
        w_cur      = i_state;
        o_high     = i_high;
        o_low      = i_low;
        o_pending  = i_pending;

        if (w_boundary && i_pending) begin
            w_cur.en  = i_sh_en;
            o_high    = i_sh_high;
            o_low     = i_sh_low;
            o_pending = 1'b0;
            if (i_sh_en && !i_state.en) begin
                w_cur.level = 1'b1;
                w_cur.cnt   = i_sh_high;
            end
        end

        o_bit   = w_cur.en & w_cur.level;
        o_state = w_cur;

        if (w_cur.en) begin
            if (w_cur.cnt > cnt_t'(1)) begin
                o_state.cnt = w_cur.cnt - cnt_t'(1);
            end else begin
                o_state.level = !w_cur.level;
                o_state.cnt   = w_cur.level ? o_low : o_high;
            end
        end
    end

endmodule

// File: rtl/eclock_pattern_gen.sv
// ---------------------------------------------------------------------------
// eclock_pattern_gen
//
// Programmable-ratio, programmable-duty clock pattern generator feeding a
// PW:1 output serializer. Every clk cycle produces one PW-bit word; high and
// low times are counted in serial bits and carry freely across words.
// Configuration changes land only at the end of a low phase, so the pin never
// sees a shortened pulse.
//   clk   : parallel-word clock
//   reset : synchronous, active-high
//   bus   : slave side of eclock_pattern_gen_if (cfg_* in; pattern/active/pending out)
// ---------------------------------------------------------------------------
module eclock_pattern_gen
    import eclock_pattern_gen_pkg::*;
#(
    parameter int PW = ECLK_PW_DEFAULT,
    parameter int DW = ECLK_DW_DEFAULT
)(
    input  logic                clk,
    input  logic                reset,
    eclock_pattern_gen_if.slave bus
);

    generate
        if (!eclk_pw_legal(PW) || DW < 1 || DW > ECLK_CNT_W) begin : g_bad_param
            $error("eclock_pattern_gen: unsupported PW or DW");
        end
    endgenerate

    logic          r_sh_en;
    cnt_t          r_sh_high;
    cnt_t          r_sh_low;
    logic          r_pending;
    step_t         r_cur;
    cnt_t          r_cur_high;
    cnt_t          r_cur_low;
    logic [PW-1:0] r_pattern;
    logic          r_active;

    logic          w_sh_en_eff;
    step_t         w_state [PW+1];
    cnt_t          w_high  [PW+1];
    cnt_t          w_low   [PW+1];
    logic [PW:0]   w_pend;
    logic [PW-1:0] w_bits;

    // A zero-length phase cannot be generated, so such a shadow behaves as a
    // disable request.
    assign w_sh_en_eff = r_sh_en && (r_sh_high != '0) && (r_sh_low != '0);

    assign w_state[0] = r_cur;
    assign w_high[0]  = r_cur_high;
    assign w_low[0]   = r_cur_low;
    assign w_pend[0]  = r_pending;

    // Bit 0 is serialized first, so the chain runs from bit 0 upward and the
    // state leaving the last step becomes next cycle's starting state.
    for (genvar g = 0; g < PW; g++) begin : g_step
        eclock_pattern_step u_step (
            .i_state   (w_state[g]),
            .i_high    (w_high[g]),
            .i_low     (w_low[g]),
            .i_pending (w_pend[g]),
            .i_sh_en   (w_sh_en_eff),
            .i_sh_high (r_sh_high),
            .i_sh_low  (r_sh_low),
            .o_state   (w_state[g+1]),
            .o_high    (w_high[g+1]),
            .o_low     (w_low[g+1]),
            .o_pending (w_pend[g+1]),
            .o_bit     (w_bits[g])
        );
    end

    // Shadow, working state and output registers. A load arriving in the same
    // cycle a boundary consumed the old shadow re-arms pending for the next
    // boundary, which is why the load takes priority over the chain's result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sh_en    <= 1'b0;
            r_sh_high  <= '0;
            r_sh_low   <= '0;
            r_pending  <= 1'b0;
            r_cur      <= '0;
            r_cur_high <= '0;
            r_cur_low  <= '0;
            r_pattern  <= '0;
            r_active   <= 1'b0;
        end else begin
            if (bus.cfg_load) begin
                r_sh_en   <= bus.cfg_en;
                r_sh_high <= cnt_t'(bus.cfg_high);
                r_sh_low  <= cnt_t'(bus.cfg_low);
                r_pending <= 1'b1;
            end else begin
                r_pending <= w_pend[PW];
            end
            r_cur      <= w_state[PW];
            r_cur_high <= w_high[PW];
            r_cur_low  <= w_low[PW];
            r_pattern  <= w_bits;
            r_active   <= w_state[PW].en;
        end
    end

    assign bus.pattern = r_pattern;
    assign bus.active  = r_active;
    assign bus.pending = r_pending;

endmodule

// File: tb/tb_eclock_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_eclock_pattern_gen
//
// Directed bench for eclock_pattern_gen at PW=8, DW=8. Each task drives one
// scenario and compares the registered outputs one time unit after the edge
// against hand-computed words.
// ---------------------------------------------------------------------------
module tb_eclock_pattern_gen;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    eclock_pattern_gen_if #(.PW(8), .DW(8)) bus ();

    eclock_pattern_gen #(.PW(8), .DW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running parallel clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a scenario never returns.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Present one configuration for exactly one sampling edge.
    task automatic drive_load(input logic en, input logic [7:0] high, input logic [7:0] low);
        bus.cfg_en   = en;
        bus.cfg_high = high;
        bus.cfg_low  = low;
        bus.cfg_load = 1'b1;
        tick();
        bus.cfg_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++;
        if (bus.pattern !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_pattern got=%h want=00", bus.pattern);
        end
        total++;
        if (bus.active !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_active got=%b want=0", bus.active);
        end
        total++;
        if (bus.pending !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_pending got=%b want=0", bus.pending);
        end
        reset = 1'b0;
        tick();
        total++;
        if (bus.pattern !== 8'h00 || bus.active !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_after_reset got=%h/%b want=00/0", bus.pattern, bus.active);
        end
    endtask

    task automatic test_ratios();
        int         ratio [3] = '{1, 2, 4};
        logic [7:0] word  [3] = '{8'h55, 8'h33, 8'h0F};
        for (int r = 0; r < 3; r++) begin
            hard_reset();
            drive_load(1'b1, 8'(ratio[r]), 8'(ratio[r]));
            total++;
            if (bus.pending !== 1'b1 || bus.pattern !== 8'h00) begin
                bad++;
                $display("[TB] FAIL ratio%0d_load pending/pattern got=%b/%h want=1/00",
                         ratio[r], bus.pending, bus.pattern);
            end
            tick();
            total++;
            if (bus.pattern !== word[r] || bus.active !== 1'b1 || bus.pending !== 1'b0) begin
                bad++;
                $display("[TB] FAIL ratio%0d_first pattern/active/pending got=%h/%b/%b want=%h/1/0",
                         ratio[r], bus.pattern, bus.active, bus.pending, word[r]);
            end
            for (int w = 0; w < 3; w++) begin
                tick();
                total++;
                if (bus.pattern !== word[r]) begin
                    bad++;
                    $display("[TB] FAIL ratio%0d_word%0d got=%h want=%h",
                             ratio[r], w + 1, bus.pattern, word[r]);
                end
            end
        end
    endtask

    task automatic test_period_10();
        logic [7:0] seq [5] = '{8'h1F, 8'h7C, 8'hF0, 8'hC1, 8'h07};
        hard_reset();
        drive_load(1'b1, 8'd5, 8'd5);
        for (int w = 0; w < 10; w++) begin
            tick();
            total++;
            if (bus.pattern !== seq[w % 5]) begin
                bad++;
                $display("[TB] FAIL period10_word%0d got=%h want=%h", w, bus.pattern, seq[w % 5]);
            end
        end
    endtask

    task automatic test_disable();
        hard_reset();
        drive_load(1'b1, 8'd4, 8'd4);
        tick();
        tick();
        total++;
        if (bus.pattern !== 8'h0F || bus.active !== 1'b1) begin
            bad++;
            $display("[TB] FAIL disable_running got=%h/%b want=0F/1", bus.pattern, bus.active);
        end
        drive_load(1'b0, 8'd4, 8'd4);
        total++;
        if (bus.pattern !== 8'h0F || bus.active !== 1'b1 || bus.pending !== 1'b1) begin
            bad++;
            $display("[TB] FAIL disable_loaded got=%h/%b/%b want=0F/1/1",
                     bus.pattern, bus.active, bus.pending);
        end
        tick();
        total++;
        if (bus.pattern !== 8'h0F || bus.active !== 1'b0 || bus.pending !== 1'b0) begin
            bad++;
            $display("[TB] FAIL disable_boundary got=%h/%b/%b want=0F/0/0",
                     bus.pattern, bus.active, bus.pending);
        end
        for (int w = 0; w < 4; w++) begin
            tick();
            total++;
            if (bus.pattern !== 8'h00 || bus.active !== 1'b0) begin
                bad++;
                $display("[TB] FAIL disabled_word%0d got=%h/%b want=00/0", w, bus.pattern, bus.active);
            end
        end
    endtask

    task automatic test_reconfig();
        hard_reset();
        drive_load(1'b1, 8'd3, 8'd5);
        tick();
        tick();
        total++;
        if (bus.pattern !== 8'h07) begin
            bad++;
            $display("[TB] FAIL reconfig_running got=%h want=07", bus.pattern);
        end
        drive_load(1'b1, 8'd1, 8'd1);
        total++;
        if (bus.pattern !== 8'h07 || bus.pending !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reconfig_loaded got=%h/%b want=07/1", bus.pattern, bus.pending);
        end
        tick();
        total++;
        if (bus.pattern !== 8'h07 || bus.pending !== 1'b0 || bus.active !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reconfig_boundary got=%h/%b/%b want=07/0/1",
                     bus.pattern, bus.pending, bus.active);
        end
        for (int w = 0; w < 2; w++) begin
            tick();
            total++;
            if (bus.pattern !== 8'h55) begin
                bad++;
                $display("[TB] FAIL reconfig_new_word%0d got=%h want=55", w, bus.pattern);
            end
        end
    endtask

    task automatic test_simultaneous();
        hard_reset();
        drive_load(1'b1, 8'd3, 8'd5);
        tick();
        drive_load(1'b1, 8'd1, 8'd1);
        drive_load(1'b1, 8'd2, 8'd2);
        total++;
        if (bus.pattern !== 8'h07 || bus.pending !== 1'b1) begin
            bad++;
            $display("[TB] FAIL simul_load_at_boundary got=%h/%b want=07/1", bus.pattern, bus.pending);
        end
        tick();
        total++;
        if (bus.pattern !== 8'hCD || bus.pending !== 1'b0) begin
            bad++;
            $display("[TB] FAIL simul_second_apply got=%h/%b want=CD/0", bus.pattern, bus.pending);
        end
        tick();
        total++;
        if (bus.pattern !== 8'hCC) begin
            bad++;
            $display("[TB] FAIL simul_steady got=%h want=CC", bus.pattern);
        end
    endtask

    task automatic test_back_to_back();
        hard_reset();
        drive_load(1'b1, 8'd8, 8'd8);
        tick();
        total++;
        if (bus.pattern !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL b2b_high_word got=%h want=FF", bus.pattern);
        end
        drive_load(1'b1, 8'd2, 8'd2);
        total++;
        if (bus.pattern !== 8'h00 || bus.pending !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_first_load got=%h/%b want=00/1", bus.pattern, bus.pending);
        end
        drive_load(1'b1, 8'd6, 8'd2);
        total++;
        if (bus.pattern !== 8'hFF || bus.pending !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_second_load got=%h/%b want=FF/1", bus.pattern, bus.pending);
        end
        tick();
        total++;
        if (bus.pattern !== 8'h00 || bus.pending !== 1'b0 || bus.active !== 1'b1) begin
            bad++;
            $display("[TB] FAIL b2b_boundary got=%h/%b/%b want=00/0/1",
                     bus.pattern, bus.pending, bus.active);
        end
        for (int w = 0; w < 3; w++) begin
            tick();
            total++;
            if (bus.pattern !== 8'h3F) begin
                bad++;
                $display("[TB] FAIL b2b_word%0d got=%h want=3F", w, bus.pattern);
            end
        end
    endtask

    task automatic test_zero_count();
        logic [7:0] hi [2] = '{8'd0, 8'd4};
        logic [7:0] lo [2] = '{8'd4, 8'd0};
        for (int c = 0; c < 2; c++) begin
            hard_reset();
            drive_load(1'b1, hi[c], lo[c]);
            tick();
            tick();
            total++;
            if (bus.pattern !== 8'h00 || bus.active !== 1'b0 || bus.pending !== 1'b0) begin
                bad++;
                $display("[TB] FAIL zero_count%0d got=%h/%b/%b want=00/0/0",
                         c, bus.pattern, bus.active, bus.pending);
            end
        end
    endtask

    task automatic test_reset_mid();
        hard_reset();
        drive_load(1'b1, 8'd5, 8'd3);
        tick();
        tick();
        total++;
        if (bus.pattern !== 8'h1F) begin
            bad++;
            $display("[TB] FAIL rstmid_running got=%h want=1F", bus.pattern);
        end
        drive_load(1'b1, 8'd1, 8'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++;
        if (bus.pattern !== 8'h00 || bus.active !== 1'b0 || bus.pending !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_cleared got=%h/%b/%b want=00/0/0",
                     bus.pattern, bus.active, bus.pending);
        end
        tick();
        tick();
        total++;
        if (bus.pattern !== 8'h00 || bus.active !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rstmid_shadow_lost got=%h/%b want=00/0", bus.pattern, bus.active);
        end
        drive_load(1'b1, 8'd5, 8'd3);
        tick();
        total++;
        if (bus.pattern !== 8'h1F || bus.active !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rstmid_restart got=%h/%b want=1F/1", bus.pattern, bus.active);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset        = 1'b1;
        bus.cfg_load = 1'b0;
        bus.cfg_en   = 1'b0;
        bus.cfg_high = 8'd0;
        bus.cfg_low  = 8'd0;

        test_reset();
        test_ratios();
        test_period_10();
        test_disable();
        test_reconfig();
        test_simultaneous();
        test_back_to_back();
        test_zero_count();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
